pipelined_barrel_shifter: RTL and testbench

- Parametrised, pipelined logarithmic barrel shifter with four shift modes and a valid/ready handshake on both sides.
- Successor to the fixed 64-bit combinational logarithmic shifter. Generalised in WIDTH, with configurable register insertion between log stages, arithmetic-right and rotate modes, per-op tag passthrough and per-stage backpressure with bubble collapse.
- Sits between the ALU operand-select stage and the result writeback mux.

---
 rtl/pipelined_barrel_shifter_if.sv | 30 +++
 rtl/pipelined_barrel_shifter.sv | 146 ++++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_barrel_shifter_if.sv
// Handshake bundle for pipelined_barrel_shifter: op request side (in_*) and
// result side (out_*), each with its own valid/ready pair.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined logarithmic barrel shifter (SLL/SRL/SRA/ROR) with a register bank
// after every REG_EVERY log stages and per-bank valid/ready flow control.
module pipelined_barrel_shifter #(
    parameter int WIDTH     = 64,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 4
) (
    input logic                       clk,
    input logic                       rst,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int LAT = (SHW + REG_EVERY - 1) / REG_EVERY;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    logic [LAT-1:0]   valid_q, valid_d;
    logic [LAT-1:0]   sign_q, sign_d;
    logic [WIDTH-1:0] data_q  [LAT];
    logic [WIDTH-1:0] data_d  [LAT];
    logic [SHW-1:0]   shamt_q [LAT];
    logic [SHW-1:0]   shamt_d [LAT];
    mode_e            mode_q  [LAT];
    mode_e            mode_d  [LAT];
    logic [TAG_W-1:0] tag_q   [LAT];
    logic [TAG_W-1:0] tag_d   [LAT];

    logic [LAT-1:0]   advance;
    logic [LAT-1:0]   up_valid;
    logic [LAT-1:0]   up_sign;
    logic [WIDTH-1:0] up_data  [LAT];
    logic [SHW-1:0]   up_shamt [LAT];
    mode_e            up_mode  [LAT];
    logic [TAG_W-1:0] up_tag   [LAT];
    logic [WIDTH-1:0] shifted  [LAT];

    function automatic logic [WIDTH-1:0] shift_stage(
        input logic [WIDTH-1:0] d,
        input int unsigned      amt,
        input mode_e            mode,
        input logic             sign
    );
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] res;
        ones = '1;
        case (mode)
            MODE_SLL: res = d << amt;
            MODE_SRL: res = d >> amt;
            MODE_SRA: res = (d >> amt) | (sign ? ~(ones >> amt) : '0);
            MODE_ROR: res = (d >> amt) | (d << (WIDTH - amt));
            default:  res = d;
        endcase
        return res;
    endfunction

    // Ready ripples back from the output; an empty bank always advances, which
    // is what lets bubbles collapse while the output is stalled.
    always_comb begin
        advance          = '0;
        advance[LAT-1]   = !valid_q[LAT-1] | bus.out_ready;
        for (int unsigned k = LAT - 1; k > 0; k--) begin
            advance[k-1] = !valid_q[k-1] | advance[k];
        end
    end

    always_comb begin
        up_valid[0] = bus.in_valid & advance[0];
        up_data[0]  = bus.in_data;
        up_shamt[0] = bus.in_shamt;
        up_mode[0]  = mode_e'(bus.in_mode);
        up_sign[0]  = bus.in_data[WIDTH-1];
        up_tag[0]   = bus.in_tag;
        for (int unsigned k = 1; k < LAT; k++) begin
            up_valid[k] = valid_q[k-1];
            up_data[k]  = data_q[k-1];
            up_shamt[k] = shamt_q[k-1];
            up_mode[k]  = mode_q[k-1];
            up_sign[k]  = sign_q[k-1];
            up_tag[k]   = tag_q[k-1];
        end
    end

    // Bank k owns log stages k*REG_EVERY .. (k+1)*REG_EVERY-1 (clipped at SHW).
    always_comb begin
        for (int unsigned k = 0; k < LAT; k++) begin
            shifted[k] = up_data[k];
            for (int unsigned s = 0; s < SHW; s++) begin
                if ((s / REG_EVERY) == k && up_shamt[k][s]) begin
                    shifted[k] = shift_stage(shifted[k], 32'd1 << s, up_mode[k], up_sign[k]);
                end
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        sign_d  = sign_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        mode_d  = mode_q;
        tag_d   = tag_q;
        for (int unsigned k = 0; k < LAT; k++) begin
            if (advance[k]) begin
                valid_d[k] = up_valid[k];
                // Payload only moves with a real op so bubbles leave it untouched.
                if (up_valid[k]) begin
                    data_d[k]  = shifted[k];
                    shamt_d[k] = up_shamt[k];
                    mode_d[k]  = up_mode[k];
                    sign_d[k]  = up_sign[k];
                    tag_d[k]   = up_tag[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            sign_q  <= '0;
            for (int unsigned k = 0; k < LAT; k++) begin
                data_q[k]  <= '0;
                shamt_q[k] <= '0;
                mode_q[k]  <= MODE_SLL;
                tag_q[k]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            sign_q  <= sign_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            mode_q  <= mode_d;
            tag_q   <= tag_d;
        end
    end

    assign bus.in_ready  = advance[0];
    assign bus.out_valid = valid_q[LAT-1];
    assign bus.out_data  = data_q[LAT-1];
    assign bus.out_tag   = tag_q[LAT-1];
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: directed vectors plus randomized traffic
// checked against an arithmetic shift model and an in-order scoreboard.
module tb_pipelined_barrel_shifter;
    localparam int WIDTH     = 64;
    localparam int TAG_W     = 4;
    localparam int REG_EVERY = 2;
    localparam int LAT       = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_barrel_shifter_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    pipelined_barrel_shifter #(
        .WIDTH(WIDTH),
        .REG_EVERY(REG_EVERY),
        .TAG_W(TAG_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  tag;
    } exp_t;

    exp_t        expq[$];
    exp_t        got_e;
    int          n_vec = 0;
    int          n_err = 0;
    logic        hold_v = 1'b0;
    logic [63:0] hold_d;
    logic [3:0]  hold_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_shift(input logic [63:0] d, input int unsigned sh, input logic [1:0] m);
        case (m)
            2'd0:    return d << sh;
            2'd1:    return d >> sh;
            2'd2:    return 64'($signed(d) >>> sh);
            default: return (sh == 0) ? d : ((d >> sh) | (d << (64 - sh)));
        endcase
    endfunction

    // Scoreboard: accepted ops queue up in order; every emitted result must match the head.
    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_data", bus.out_data, hold_d);
                check("hold_tag", 64'(bus.out_tag), 64'(hold_t));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    check("spurious_result", 64'd1, 64'd0);
                end else begin
                    got_e = expq.pop_front();
                    check("sb_data", bus.out_data, got_e.data);
                    check("sb_tag", 64'(bus.out_tag), 64'(got_e.tag));
                end
            end
            if (bus.in_valid && bus.in_ready)
                expq.push_back('{ref_shift(bus.in_data, bus.in_shamt, bus.in_mode), bus.in_tag});
            hold_v = bus.out_valid && !bus.out_ready;
            hold_d = bus.out_data;
            hold_t = bus.out_tag;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_op();
        bus.in_data  = {$urandom, $urandom};
        bus.in_shamt = 6'($urandom_range(0, 63));
        bus.in_mode  = 2'($urandom_range(0, 3));
    endtask

    task automatic send_one(input logic [63:0] d, input logic [5:0] sh, input logic [1:0] m,
                            input logic [3:0] tg, input logic [63:0] exp_d);
        int t;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_shamt  = sh;
        bus.in_mode   = m;
        bus.in_tag    = tg;
        #1;
        t = 0;
        while (!bus.in_ready && t < 20) begin
            step(1);
            t++;
        end
        check("dir_accept", 64'(bus.in_ready), 64'd1);
        step(1);
        bus.in_valid = 1'b0;
        t = 0;
        while (!bus.out_valid && t < 20) begin
            step(1);
            t++;
        end
        check("dir_latency", 64'(t), 64'(LAT - 1));
        check("dir_data", bus.out_data, exp_d);
        check("dir_tag", 64'(bus.out_tag), 64'(tg));
    endtask

    task automatic drain();
        int t;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        t = 0;
        while (expq.size() != 0 && t < 50) begin
            step(1);
            t++;
        end
        step(1);
        check("drain_empty", 64'(expq.size()), 64'd0);
        check("drain_out_valid", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc;
        int  tg;
        logic pend;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rand_op();
        bus.in_tag    = '0;
        step(2);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        send_one(64'h1, 6'd63, 2'd0, 4'd5, 64'h8000_0000_0000_0000);
        send_one(64'h8000_0000_0000_0000, 6'd4, 2'd2, 4'd1, 64'hF800_0000_0000_0000);
        send_one(64'h8000_0000_0000_0000, 6'd4, 2'd1, 4'd2, 64'h0800_0000_0000_0000);
        send_one(64'h8000_0000_0000_0000, 6'd4, 2'd0, 4'd3, 64'h0);
        send_one(64'hF1, 6'd4, 2'd3, 4'd4, 64'h1000_0000_0000_000F);
        for (int m = 0; m < 4; m++)
            send_one(64'hF1, 6'd0, 2'(m), 4'(m + 6), 64'hF1);
        send_one(64'h7123_4567_89AB_CDEF, 6'd12, 2'd2, 4'd10, 64'h0007_1234_5678_9ABC);
        drain();

        // Streaming: 8 back-to-back ops, results on 8 consecutive cycles.
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                bus.in_valid = 1'b1;
                bus.in_tag   = 4'(c);
                rand_op();
                #1;
                check("stream_in_ready", 64'(bus.in_ready), 64'd1);
            end else begin
                bus.in_valid = 1'b0;
            end
            step(1);
            check("stream_out_valid", 64'(bus.out_valid), 64'((c >= 2) && (c <= 9)));
            if (c >= 2) check("stream_tag", 64'(bus.out_tag), 64'(c - 2));
        end
        drain();

        // Backpressure: stalled output, fill to capacity.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        tg = 8;
        bus.in_tag = 4'(tg);
        rand_op();
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            pend = !bus.in_ready;
            if (bus.in_ready) acc++;
            step(1);
            if (!pend) begin
                tg++;
                bus.in_tag = 4'(tg);
                rand_op();
            end
        end
        #1;
        check("bp_accepted", 64'(acc), 64'(LAT));
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        drain();

        // Bubble in the input stream collapses while the output is stalled.
        bus.out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 7; c++) begin
            bus.in_valid = (c != 1);
            bus.in_tag   = 4'(c);
            rand_op();
            #1;
            if (bus.in_valid && bus.in_ready) acc++;
            step(1);
        end
        #1;
        check("bubble_accepted", 64'(acc), 64'(LAT));
        check("bubble_in_ready", 64'(bus.in_ready), 64'd0);
        drain();

        // Reset with ops in flight.
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = 1'b1;
            bus.in_tag   = 4'(c + 12);
            rand_op();
            step(1);
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_out_data", bus.out_data, 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        for (int c = 0; c < 3; c++) begin
            step(1);
            check("post_rst_quiet", 64'(bus.out_valid), 64'd0);
        end
        send_one(64'h8000_0000_0000_0000, 6'd63, 2'd2, 4'd9, 64'hFFFF_FFFF_FFFF_FFFF);
        drain();

        // Randomized traffic with random backpressure.
        pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!pend) begin
                bus.in_valid = ($urandom_range(0, 9) < 7);
                bus.in_tag   = 4'($urandom_range(0, 15));
                rand_op();
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            #1;
            pend = bus.in_valid && !bus.in_ready;
            step(1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
